// File: rtl/ap_ctrl_profiler.sv
// Profiles ap_ctrl_hs start/done handshakes of an observed block and queues
// {start, latency, incomplete} records in a first-word fall-through FIFO.
module ap_ctrl_profiler #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_done,
    input  logic             ap_ready,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [CNT_W-1:0] rec_start,
    output logic [CNT_W-1:0] rec_latency,
    output logic             rec_incomplete,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] ready_count,
    output logic             dropped,
    output logic             profiler_done
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CntOne = 1;
    localparam logic [PtrW:0] PtrOne = 1;

    typedef enum logic [1:0] {StIdle, StBusy, StFinished} state_e;

    typedef struct packed {
        logic [CNT_W-1:0] start;
        logic [CNT_W-1:0] latency;
        logic             incomplete;
    } rec_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] start_ts_q, start_ts_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic [CNT_W-1:0] ready_q, ready_d;
    logic             dropped_q, dropped_d;
    logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
    rec_t             mem_q [FIFO_DEPTH];
    rec_t             mem_d [FIFO_DEPTH];
    rec_t             new_rec;
    rec_t             head_rec;
    logic             push_req, push_ok, pop, empty, full, out_en;

    always_comb begin
        state_d    = state_q;
        start_ts_d = start_ts_q;
        push_req   = 1'b0;
        new_rec    = '0;
        unique case (state_q)
            StIdle: begin
                if (finish) begin
                    state_d = StFinished;
                end else if (ap_start) begin
                    if (ap_done) begin
                        push_req      = 1'b1;
                        new_rec.start = cyc_q;
                    end else begin
                        start_ts_d = cyc_q;
                        state_d    = StBusy;
                    end
                end
            end
            StBusy: begin
                // finish without done closes the open transaction as incomplete
                if (ap_done || finish) begin
                    push_req           = 1'b1;
                    new_rec.start      = start_ts_q;
                    new_rec.latency    = cyc_q - start_ts_q;
                    new_rec.incomplete = !ap_done;
                end
                if (finish) begin
                    state_d = StFinished;
                end else if (ap_done) begin
                    if (ap_start) begin
                        start_ts_d = cyc_q;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StFinished: ;
            default: state_d = StIdle;
        endcase
    end

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign pop      = !empty && rec_ready;
    assign push_ok  = push_req && (!full || pop);
    assign head_rec = mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cyc_d     = cyc_q + CntOne;
        txn_d     = txn_q;
        ready_d   = ready_q;
        dropped_d = dropped_q | (push_req && !push_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q[PtrW-1:0]] = new_rec;
            wr_ptr_d                  = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        // completed transactions are counted even when their record is dropped
        if (push_req && !new_rec.incomplete && (txn_q != '1)) begin
            txn_d = txn_q + CntOne;
        end
        if (ap_ready && (state_q != StFinished) && (ready_q != '1)) begin
            ready_d = ready_q + CntOne;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cyc_q      <= '0;
            start_ts_q <= '0;
            txn_q      <= '0;
            ready_q    <= '0;
            dropped_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            start_ts_q <= start_ts_d;
            txn_q      <= txn_d;
            ready_q    <= ready_d;
            dropped_q  <= dropped_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Outputs are forced low while reset is asserted so they read zero immediately.
    assign out_en         = !reset && !empty;
    assign rec_valid      = out_en;
    assign rec_start      = out_en ? head_rec.start : '0;
    assign rec_latency    = out_en ? head_rec.latency : '0;
    assign rec_incomplete = out_en && head_rec.incomplete;
    assign txn_count      = reset ? '0 : txn_q;
    assign ready_count    = reset ? '0 : ready_q;
    assign dropped        = !reset && dropped_q;
    assign profiler_done  = !reset && (state_q == StFinished) && empty;

endmodule
